// File: rtl/led_frame_scheduler_pkg.sv
// rtl/led_frame_scheduler_pkg.sv - shared types and constants for the LED frame scheduler
// Contents: FRAME_W, display source state enum, LED bit-field positions, led_dark() pin idle value.
package led_pkg;

   localparam int FRAME_W = 12;

   // Each LED occupies three bits {R,G,B}; these are the LSB positions in a frame word.
   localparam int LED7_LSB = 9;
   localparam int LED8_LSB = 6;
   localparam int LED5_LSB = 3;
   localparam int LED6_LSB = 0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GAME     = 2'd1,
      OVERRIDE = 2'd2
   } state_e;

   // Pin drive that leaves every channel unlit for the given polarity.
   function automatic logic [FRAME_W-1:0] led_dark(input logic active_low);
      return active_low ? {FRAME_W{1'b1}} : {FRAME_W{1'b0}};
   endfunction

endpackage

// File: rtl/led_frame_scheduler_pwm.sv
// rtl/led_frame_scheduler_pwm.sv - global PWM brightness and registered LED pin drive
// Ports:
//   clk        in   1         clock
//   rst        in   1         synchronous active-high reset
//   brightness in   PWM_BITS  requested duty, sampled only at the end of a PWM period
//   disp       in   FRAME_W   frame currently selected for display
//   led_n      out  FRAME_W   registered pin drive, inverted when ACTIVE_LOW != 0
module led_pwm
   import led_pkg::*;
#(
   parameter int PWM_BITS   = 4,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PWM_BITS-1:0] brightness,
   input  logic [FRAME_W-1:0]  disp,
   output logic [FRAME_W-1:0]  led_n
);

   localparam logic                ACT_LOW = (ACTIVE_LOW != 0);
   localparam logic [PWM_BITS-1:0] PWM_MAX = {PWM_BITS{1'b1}};

   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [PWM_BITS-1:0] bright_q, bright_d;
   logic [FRAME_W-1:0]  led_n_q, led_n_d;
   logic [FRAME_W-1:0]  lit;

   always_comb begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      // Brightness only changes on the period boundary so a period never mixes two duties.
      bright_d  = (pwm_cnt_q == PWM_MAX) ? brightness : bright_q;
      lit       = (pwm_cnt_q < bright_q) ? disp : {FRAME_W{1'b0}};
      led_n_d   = ACT_LOW ? ~lit : lit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt_q <= '0;
         bright_q  <= '0;
         led_n_q   <= led_dark(ACT_LOW);
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
         bright_q  <= bright_d;
         led_n_q   <= led_n_d;
      end
   end

   assign led_n = led_n_q;

endmodule

// File: rtl/led_frame_scheduler.sv
// rtl/led_frame_scheduler.sv - game tick, tear-free frame capture, override hold and LED drive
// Ports:
//   _i_clk        in   1         clock
//   _i_rst        in   1         synchronous active-high reset
//   _i_brightness in   PWM_BITS  global brightness (lit while pwm_cnt < brightness)
//   game_tick     out  1         one-cycle pulse every TICK_LEN cycles
//   game_valid    in   1         game frame offered
//   game_frame    in   FRAME_W   game frame, {LED7,LED8,LED5,LED6} x {R,G,B}
//   game_ready    out  1         game frame accepted when valid && ready
//   ovr_valid     in   1         override frame offered
//   ovr_frame     in   FRAME_W   override frame, same bit map
//   ovr_ready     out  1         override accepted when valid && ready
//   src_is_ovr    out  1         high while the override owns the display
//   led_n         out  FRAME_W   registered pin drive
module led_frame_scheduler
   import led_pkg::*;
#(
   parameter int TICK_LEN   = 160_000,
   parameter int HOLD_TICKS = 50,
   parameter int PWM_BITS   = 4,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                _i_clk,
   input  logic                _i_rst,
   input  logic [PWM_BITS-1:0] _i_brightness,
   output logic                game_tick,
   input  logic                game_valid,
   input  logic [FRAME_W-1:0]  game_frame,
   output logic                game_ready,
   input  logic                ovr_valid,
   input  logic [FRAME_W-1:0]  ovr_frame,
   output logic                ovr_ready,
   output logic                src_is_ovr,
   output logic [FRAME_W-1:0]  led_n
);

   localparam int              TW        = $clog2(TICK_LEN);
   localparam int              HW        = $clog2(HOLD_TICKS + 1);
   localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_LEN - 1);
   localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLD_TICKS);
   localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);

   state_e             state_q, state_d;
   logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic [FRAME_W-1:0] game_buf_q, game_buf_d;
   logic               game_buf_vld_q, game_buf_vld_d;
   logic [FRAME_W-1:0] disp_q, disp_d;
   logic               game_tick_q, game_tick_d;
   logic               src_is_ovr_q, src_is_ovr_d;
   logic               game_acc, ovr_acc;

   // Both sources are always accepted outside reset; only the display choice is arbitrated.
   assign game_ready = ~_i_rst;
   assign ovr_ready  = ~_i_rst;

   always_comb begin
      game_acc       = game_valid & game_ready;
      ovr_acc        = ovr_valid & ovr_ready;

      tick_cnt_d     = game_tick_q ? '0 : tick_cnt_q + 1'b1;

      // The buffer always tracks the latest accepted game frame, whatever owns the display.
      game_buf_d     = game_acc ? game_frame : game_buf_q;
      game_buf_vld_d = game_buf_vld_q | game_acc;

      state_d        = state_q;
      hold_d         = hold_q;
      disp_d         = disp_q;

      // game_buf_d is used on tick cycles so a frame accepted in the tick cycle itself is shown.
      case (state_q)
         IDLE: begin
            disp_d = '0;
            if (game_tick_q && game_buf_vld_d) begin
               state_d = GAME;
               disp_d  = game_buf_d;
            end
         end
         GAME: begin
            if (game_tick_q) begin
               disp_d = game_buf_d;
            end
         end
         OVERRIDE: begin
            if (game_tick_q) begin
               if (hold_q == HOLD_ONE) begin
                  hold_d = '0;
                  if (game_buf_vld_d) begin
                     state_d = GAME;
                     disp_d  = game_buf_d;
                  end else begin
                     state_d = IDLE;
                     disp_d  = '0;
                  end
               end else begin
                  hold_d = hold_q - 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            disp_d  = '0;
         end
      endcase

      // A fresh override beats everything above, including a hold expiry in the same cycle.
      if (ovr_acc) begin
         state_d = OVERRIDE;
         hold_d  = HOLD_LOAD;
         disp_d  = ovr_frame;
      end

      game_tick_d  = (tick_cnt_d == TICK_LAST);
      src_is_ovr_d = (state_d == OVERRIDE);
   end

   always_ff @(posedge _i_clk) begin
      if (_i_rst) begin
         state_q        <= IDLE;
         tick_cnt_q     <= '0;
         hold_q         <= '0;
         game_buf_q     <= '0;
         game_buf_vld_q <= 1'b0;
         disp_q         <= '0;
         game_tick_q    <= 1'b0;
         src_is_ovr_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         tick_cnt_q     <= tick_cnt_d;
         hold_q         <= hold_d;
         game_buf_q     <= game_buf_d;
         game_buf_vld_q <= game_buf_vld_d;
         disp_q         <= disp_d;
         game_tick_q    <= game_tick_d;
         src_is_ovr_q   <= src_is_ovr_d;
      end
   end

   assign game_tick  = game_tick_q;
   assign src_is_ovr = src_is_ovr_q;

   led_pwm #(
      .PWM_BITS  (PWM_BITS),
      .ACTIVE_LOW(ACTIVE_LOW)
   ) u_pwm (
      .clk       (_i_clk),
      .rst       (_i_rst),
      .brightness(_i_brightness),
      .disp      (disp_q),
      .led_n     (led_n)
   );

endmodule

// File: tb/tb_led_frame_scheduler.sv
// tb/tb_led_frame_scheduler.sv - scoreboard bench for led_frame_scheduler
module tb_led_frame_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  bright;
   logic        game_tick;
   logic        game_valid;
   logic [11:0] game_frame;
   logic        game_ready;
   logic        ovr_valid;
   logic [11:0] ovr_frame;
   logic        ovr_ready;
   logic        src_is_ovr;
   logic [11:0] led_n;

   always #5 clk = ~clk;

   led_frame_scheduler #(
      .TICK_LEN  (8),
      .HOLD_TICKS(2),
      .PWM_BITS  (4),
      .ACTIVE_LOW(1)
   ) dut (
      ._i_clk       (clk),
      ._i_rst       (rst),
      ._i_brightness(bright),
      .game_tick    (game_tick),
      .game_valid   (game_valid),
      .game_frame   (game_frame),
      .game_ready   (game_ready),
      .ovr_valid    (ovr_valid),
      .ovr_frame    (ovr_frame),
      .ovr_ready    (ovr_ready),
      .src_is_ovr   (src_is_ovr),
      .led_n        (led_n)
   );

   typedef struct {
      int          c;
      bit          is_src;
      logic [11:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   rst_edge = 1'b0;

   // Active-low pin value for frame f at cycle c, given brightness b in force one cycle earlier.
   function automatic logic [11:0] exp_led(input logic [11:0] f, input int c, input int b);
      int pc;
      pc = (c - 1) % 16;
      return (pc < b) ? ~f : 12'hFFF;
   endfunction

   task automatic push_led(input int c, input logic [11:0] v, input string n);
      exp_t e;
      e.c = c; e.is_src = 1'b0; e.val = v; e.name = n;
      sb.push_back(e);
   endtask

   task automatic push_src(input int c, input logic v, input string n);
      exp_t e;
      e.c = c; e.is_src = 1'b1; e.val = {11'd0, v}; e.name = n;
      sb.push_back(e);
   endtask

   task automatic check(input string n, input logic [11:0] act, input logic [11:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, act, want);
      end
   endtask

   always @(posedge clk) rst_edge = rst;

   // Monitor: checks reset outputs, per-cycle tick/ready, and pops scoreboard entries due this cycle.
   always @(negedge clk) begin
      if (rst) begin
         if (rst_edge) begin
            check("rst_led", led_n, 12'hFFF);
            check("rst_tick", {11'd0, game_tick}, 12'd0);
            check("rst_ready", {10'd0, game_ready, ovr_ready}, 12'd0);
            check("rst_src", {11'd0, src_is_ovr}, 12'd0);
         end
         cyc = 0;
      end else begin
         check("tick", {11'd0, game_tick}, {11'd0, (cyc % 8) == 7});
         check("ready", {10'd0, game_ready, ovr_ready}, 12'd3);
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].c <= cyc) begin
               if (sb[i].c < cyc) begin
                  total++;
                  bad++;
                  $display("FAIL %s missed cyc=%0d", sb[i].name, sb[i].c);
               end else if (sb[i].is_src) begin
                  check(sb[i].name, {11'd0, src_is_ovr}, sb[i].val);
               end else begin
                  check(sb[i].name, led_n, sb[i].val);
               end
               sb.delete(i);
            end
         end
         cyc++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) step();
   endtask

   task automatic game_at(input int c, input logic [11:0] f);
      wait_cyc(c);
      game_valid = 1'b1; game_frame = f;
      step();
      game_valid = 1'b0;
   endtask

   task automatic ovr_at(input int c, input logic [11:0] f);
      wait_cyc(c);
      ovr_valid = 1'b1; ovr_frame = f;
      step();
      ovr_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; bright = 4'd15;
      game_valid = 1'b0; game_frame = '0; ovr_valid = 1'b0; ovr_frame = '0;
      repeat (3) step();
      rst = 1'b0;

      // Override with empty game buffer, expiry to IDLE, then reload on the expiry tick.
      push_led(17, 12'hFFF, "idle_dark");
      push_src(19, 1'b1, "ovr1_src");
      push_led(20, exp_led(12'hC3C, 20, 15), "ovr1_led");
      push_led(31, exp_led(12'hC3C, 31, 15), "ovr1_hold");
      push_src(31, 1'b1, "ovr1_src_hold");
      push_src(32, 1'b0, "ovr1_exit_src");
      push_led(33, 12'hFFF, "ovr1_exit_idle");
      push_led(34, 12'hFFF, "ovr1_idle2");
      ovr_at(18, 12'hC3C);
      push_led(38, exp_led(12'h707, 38, 15), "ovr2_led");
      push_src(48, 1'b1, "reload_src");
      push_led(49, exp_led(12'h070, 49, 15), "reload_led");
      push_src(50, 1'b1, "reload_src2");
      push_led(62, exp_led(12'h070, 62, 15), "reload_hold");
      push_src(63, 1'b1, "reload_src3");
      push_src(64, 1'b0, "reload_exit_src");
      push_led(65, 12'hFFF, "reload_exit_idle");
      ovr_at(36, 12'h707);
      ovr_at(47, 12'h070);

      // Simultaneous game + override: override shows, game frame follows after expiry.
      push_src(67, 1'b1, "both_src");
      push_led(68, exp_led(12'h888, 68, 15), "both_ovr");
      push_led(79, exp_led(12'h888, 79, 15), "both_hold");
      push_src(79, 1'b1, "both_src_hold");
      push_src(80, 1'b0, "both_exit_src");
      push_led(81, exp_led(12'h111, 81, 15), "both_game");
      wait_cyc(66);
      game_valid = 1'b1; game_frame = 12'h111; ovr_valid = 1'b1; ovr_frame = 12'h888;
      step();
      game_valid = 1'b0; ovr_valid = 1'b0;

      // Game frame accepted in the tick cycle is the one displayed.
      push_led(88, exp_led(12'h111, 88, 15), "tickacc_old");
      push_led(89, exp_led(12'h222, 89, 15), "tickacc_new");
      game_at(87, 12'h222);

      // Mid-run reset with both sources offering frames.
      wait_cyc(92);
      rst = 1'b1;
      game_valid = 1'b1; game_frame = 12'h999; ovr_valid = 1'b1; ovr_frame = 12'h666;
      repeat (3) step();
      rst = 1'b0; game_valid = 1'b0; ovr_valid = 1'b0;

      push_led(5, 12'hFFF, "post_rst_dark");
      push_led(17, 12'hFFF, "post_rst_nobuf");
      push_led(18, 12'hFFF, "post_rst_nobuf2");
      push_src(18, 1'b0, "post_rst_src");

      // Game frame mid-tick waits for the tick boundary.
      push_led(20, 12'hFFF, "game_wait1");
      push_led(24, 12'hFFF, "game_wait2");
      push_led(25, exp_led(12'hA5A, 25, 15), "game_shown");
      push_led(26, exp_led(12'hA5A, 26, 15), "game_shown2");
      push_led(32, exp_led(12'hA5A, 32, 15), "pwm_off_slot");
      game_at(19, 12'hA5A);

      // Override in GAME, game frame buffered during it, return to latest game frame.
      push_led(35, exp_led(12'hA5A, 35, 15), "ovr3_pre");
      push_src(35, 1'b1, "ovr3_src");
      push_led(36, exp_led(12'h0F0, 36, 15), "ovr3_led");
      push_led(44, exp_led(12'h0F0, 44, 15), "ovr3_buffered");
      push_src(47, 1'b1, "ovr3_src_hold");
      push_led(47, exp_led(12'h0F0, 47, 15), "ovr3_hold");
      push_led(48, exp_led(12'h0F0, 48, 15), "ovr3_edge");
      push_src(48, 1'b0, "ovr3_exit_src");
      push_led(49, exp_led(12'h3C3, 49, 15), "ovr3_latest");
      ovr_at(34, 12'h0F0);
      game_at(42, 12'h3C3);

      // Brightness 4 then 8 on a full frame; changes land only after a PWM wrap.
      game_at(50, 12'hFFF);
      wait_cyc(52);
      bright = 4'd4;
      for (int c = 58; c <= 112; c++) begin
         int b;
         b = (c - 1 < 64) ? 15 : ((c - 1 < 96) ? 4 : 8);
         push_led(c, exp_led(12'hFFF, c, b), $sformatf("pwm_b%0d", b));
      end
      wait_cyc(84);
      bright = 4'd8;
      wait_cyc(115);

      foreach (sb[i]) begin
         total++;
         bad++;
         $display("FAIL %s never checked cyc=%0d", sb[i].name, sb[i].c);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
